// File: rtl/bank_color_fader.sv
// bank_color_fader: palette-driven RGB fader.
// A bank index selects a colour from a small writable palette. The displayed
// colour fades toward it at a bounded rate per fade tick. The colour is then
// held for a fixed number of ticks and decays back to black.
// Optional feature macro: BANK_COLOR_FADE_EN.
//   - Defined: colour changes ramp gradually, one bounded step per tick.
//   - Undefined: colour changes take effect on the next edge; the hold is
//     still timed by the prescaler.
module bank_color_fader #(
  parameter int NUM_BANKS  = 16,
  parameter int IDX_W      = 5,
  parameter int CW         = 8,
  parameter int STEP       = 8,
  parameter int TICK_DIV   = 50000,
  parameter int HOLD_TICKS = 100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bank_valid,
  input  logic [IDX_W-1:0]  bank_idx,
  output logic              bank_ready,
  input  logic              pal_we,
  input  logic [IDX_W-1:0]  pal_addr,
  input  logic [3*CW-1:0]   pal_data,
  output logic [CW-1:0]     R,
  output logic [CW-1:0]     G,
  output logic [CW-1:0]     B,
  output logic              busy,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FADE  = 2'd1,
    S_SHOW  = 2'd2,
    S_DECAY = 2'd3
  } state_t;

  // The palette index uses just enough bits to cover NUM_BANKS.
  // Out-of-range indices are filtered before any palette access.
  localparam int AW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int PW = $clog2(TICK_DIV);
  localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_TICKS);

  logic [3*CW-1:0] palette [NUM_BANKS];
  state_t          st;
  logic [PW-1:0]   presc;
  logic            tick;
  logic [HW-1:0]   hold;
  logic            accept;
  logic [3*CW-1:0] new_tgt;
  logic [3*CW-1:0] rgb;

  assign rgb        = {R, G, B};
  assign accept     = bank_valid && bank_ready;
  assign tick       = (presc == TICK_LAST);
  assign state      = st;
  assign busy       = (st == S_FADE) || (st == S_DECAY);
  assign bank_ready = (st != S_FADE);

  // Palette storage. Writes are independent of the fader state.
  // Writes to addresses at or beyond NUM_BANKS are dropped.
  // NOTE: the palette is cleared by reset. Palette entries are read back as
  // black after a reset, so this array must be flops, not a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BANKS; i++) palette[i] <= '0;
    end else if (pal_we && (int'(pal_addr) < NUM_BANKS)) begin
      palette[pal_addr[AW-1:0]] <= pal_data;
    end
  end

  // Target chosen by the offered index. Out-of-range indices select black.
  // The read sees the pre-write palette, so a write on the accept edge
  // does not leak into the target.
  // NOTE: give every always_comb output a default first. Without one, an
  // uncovered path infers a latch.
  always_comb begin
    new_tgt = '0;
    if (int'(bank_idx) < NUM_BANKS) new_tgt = palette[bank_idx[AW-1:0]];
  end

  // Free-running prescaler. It produces a single-cycle tick every TICK_DIV clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + PW'(1);
  end

`ifdef BANK_COLOR_FADE_EN
  logic [3*CW-1:0] tgt;
  logic            at_tgt;
  logic            is_black;

  assign at_tgt   = (rgb == tgt);
  assign is_black = (rgb == '0);

  // Move one channel toward its target by at most STEP. The arithmetic uses
  // one extra bit, so a step can neither wrap nor overshoot.
  function automatic logic [CW-1:0] step_toward(input logic [CW-1:0] cur,
                                                input logic [CW-1:0] dst);
    logic [CW:0] stp;
    logic [CW:0] diff;
    logic [CW:0] moved;
    stp = (CW+1)'(STEP);
    if (dst >= cur) begin
      diff  = {1'b0, dst} - {1'b0, cur};
      moved = {1'b0, cur} + stp;
    end else begin
      diff  = {1'b0, cur} - {1'b0, dst};
      moved = {1'b0, cur} - stp;
    end
    return (diff > stp) ? moved[CW-1:0] : dst;
  endfunction
`endif

  // Fader state machine. It owns the displayed colour, the target and the hold counter.
  // NOTE: state registers use non-blocking assignments. Every flop then
  // samples the values from before the edge, whatever the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= S_IDLE;
      R    <= '0;
      G    <= '0;
      B    <= '0;
      hold <= '0;
`ifdef BANK_COLOR_FADE_EN
      tgt  <= '0;
`endif
    end else if (accept) begin
`ifdef BANK_COLOR_FADE_EN
      tgt <= new_tgt;
      st  <= S_FADE;
`else
      {R, G, B} <= new_tgt;
      st        <= S_SHOW;
      hold      <= HOLD_LOAD;
`endif
    end else begin
      case (st)
        S_FADE: begin
`ifdef BANK_COLOR_FADE_EN
          if (at_tgt) begin
            st   <= S_SHOW;
            hold <= HOLD_LOAD;
          end else if (tick) begin
            R <= step_toward(R, tgt[3*CW-1:2*CW]);
            G <= step_toward(G, tgt[2*CW-1:CW]);
            B <= step_toward(B, tgt[CW-1:0]);
          end
`else
          // Not entered in this build. Recover to SHOW if it ever is.
          st   <= S_SHOW;
          hold <= HOLD_LOAD;
`endif
        end
        S_SHOW: begin
          if (tick) begin
            if (hold <= HW'(1)) begin
              st   <= S_DECAY;
              hold <= '0;
`ifdef BANK_COLOR_FADE_EN
              tgt  <= '0;
`endif
            end else begin
              hold <= hold - HW'(1);
            end
          end
        end
        S_DECAY: begin
`ifdef BANK_COLOR_FADE_EN
          if (is_black) begin
            st <= S_IDLE;
          end else if (tick) begin
            R <= step_toward(R, tgt[3*CW-1:2*CW]);
            G <= step_toward(G, tgt[2*CW-1:CW]);
            B <= step_toward(B, tgt[CW-1:0]);
          end
`else
          {R, G, B} <= '0;
          st        <= S_IDLE;
`endif
        end
        default: begin
          // IDLE: nothing to do until an index is accepted.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bank_color_fader.sv
// Directed testbench for bank_color_fader.
// It uses TICK_DIV=4, STEP=64, HOLD_TICKS=3 and CW=8. The stimulus follows
// whichever build of BANK_COLOR_FADE_EN the design is compiled with.
module tb_bank_color_fader;

  localparam int NUM_BANKS  = 16;
  localparam int IDX_W      = 5;
  localparam int CW         = 8;
  localparam int STEP       = 64;
  localparam int TICK_DIV   = 4;
  localparam int HOLD_TICKS = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FADE  = 2'd1;
  localparam logic [1:0] ST_SHOW  = 2'd2;
  localparam logic [1:0] ST_DECAY = 2'd3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             bank_valid;
  logic [IDX_W-1:0] bank_idx;
  logic             bank_ready;
  logic             pal_we;
  logic [IDX_W-1:0] pal_addr;
  logic [3*CW-1:0]  pal_data;
  logic [CW-1:0]    R;
  logic [CW-1:0]    G;
  logic [CW-1:0]    B;
  logic             busy;
  logic [1:0]       state;

  int checks   = 0;
  int failures = 0;

  bank_color_fader #(
    .NUM_BANKS (NUM_BANKS),
    .IDX_W     (IDX_W),
    .CW        (CW),
    .STEP      (STEP),
    .TICK_DIV  (TICK_DIV),
    .HOLD_TICKS(HOLD_TICKS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bank_valid(bank_valid),
    .bank_idx  (bank_idx),
    .bank_ready(bank_ready),
    .pal_we    (pal_we),
    .pal_addr  (pal_addr),
    .pal_data  (pal_data),
    .R         (R),
    .G         (G),
    .B         (B),
    .busy      (busy),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges and sample 1 time unit after the last one.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_rgb(input string tag, input logic [23:0] exp);
    check(tag, {8'h00, R, G, B}, {8'h00, exp});
  endtask

  // Wait (bounded) for the colour to change, then compare the new colour.
  task automatic wait_rgb(input string tag, input logic [23:0] exp);
    logic [23:0] old;
    int n;
    old = {R, G, B};
    n = 0;
    while ({R, G, B} === old && n < 8) begin
      cyc(1);
      n++;
    end
    check_rgb(tag, exp);
  endtask

  // Wait (bounded) for a state, report cycles spent, compare the state.
  task automatic wait_state(input string tag, input logic [1:0] exp, input int budget,
                            output int n);
    n = 0;
    while (state !== exp && n < budget) begin
      cyc(1);
      n++;
    end
    check(tag, {30'd0, state}, {30'd0, exp});
  endtask

  task automatic pal_write(input logic [IDX_W-1:0] addr, input logic [23:0] data);
    pal_we   = 1'b1;
    pal_addr = addr;
    pal_data = data;
    cyc(1);
    pal_we   = 1'b0;
  endtask

  task automatic offer(input logic [IDX_W-1:0] idx);
    bank_valid = 1'b1;
    bank_idx   = idx;
    cyc(1);
    bank_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst_n      = 1'b0;
    bank_valid = 1'b0;
    bank_idx   = '0;
    pal_we     = 1'b0;
    pal_addr   = '0;
    pal_data   = '0;

    // Reset state, before any clock edge.
    #1;
    check_rgb("reset_rgb", 24'h000000);
    check("reset_state", {30'd0, state}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_ready", {31'd0, bank_ready}, 32'd1);
    cyc(2);
    rst_n = 1'b1;

    pal_write(5'd3, 24'hFF8000);

`ifdef BANK_COLOR_FADE_EN
    // Full fade-up to palette[3].
    offer(5'd3);
    check("fade_state", {30'd0, state}, {30'd0, ST_FADE});
    check("fade_busy", {31'd0, busy}, 32'd1);
    check("fade_ready", {31'd0, bank_ready}, 32'd0);
    wait_rgb("up1", 24'h404000);
    wait_rgb("up2", 24'h808000);
    wait_rgb("up3", 24'hC08000);
    wait_rgb("up4", 24'hFF8000);
    wait_state("show", ST_SHOW, 4, n);
    check("show_ready", {31'd0, bank_ready}, 32'd1);
    check("show_busy", {31'd0, busy}, 32'd0);

    // Hold expiry: three ticks after SHOW is entered, which is 11 cycles.
    wait_state("decay", ST_DECAY, 20, n);
    check("hold_cycles", n, 32'd11);
    wait_rgb("dn1", 24'hBF4000);
    wait_rgb("dn2", 24'h7F0000);
    wait_rgb("dn3", 24'h3F0000);
    wait_rgb("dn4", 24'h000000);
    wait_state("idle", ST_IDLE, 4, n);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Out-of-range index in SHOW, with bank_valid held high through FADE.
    offer(5'd3);
    wait_state("show2", ST_SHOW, 40, n);
    bank_valid = 1'b1;
    bank_idx   = 5'd20;
    cyc(1);
    bank_idx   = 5'd3;
    check("oor_fade", {30'd0, state}, {30'd0, ST_FADE});
    check("oor_ready", {31'd0, bank_ready}, 32'd0);
    wait_rgb("oor1", 24'hBF4000);
    wait_rgb("oor2", 24'h7F0000);
    wait_rgb("oor3", 24'h3F0000);
    wait_rgb("oor4", 24'h000000);
    bank_valid = 1'b0;
    wait_state("oor_show", ST_SHOW, 4, n);
    check_rgb("oor_black", 24'h000000);
    wait_state("oor_idle", ST_IDLE, 20, n);

    // Write collision: the target takes the old (black) entry and SHOW follows at once.
    pal_we     = 1'b1;
    pal_addr   = 5'd5;
    pal_data   = 24'h0A141E;
    bank_valid = 1'b1;
    bank_idx   = 5'd5;
    cyc(1);
    pal_we     = 1'b0;
    bank_valid = 1'b0;
    check("coll_fade", {30'd0, state}, {30'd0, ST_FADE});
    cyc(1);
    check("coll_show", {30'd0, state}, {30'd0, ST_SHOW});
    check_rgb("coll_rgb", 24'h000000);
    offer(5'd5);
    wait_rgb("pal5", 24'h0A141E);
    wait_state("pal5_show", ST_SHOW, 8, n);

    // A write to address 16 must not alias onto entry 0.
    pal_write(5'd16, 24'hFFFFFF);
    offer(5'd0);
    wait_rgb("pal0", 24'h000000);
    wait_state("pal0_show", ST_SHOW, 8, n);

    // Asynchronous reset between edges in the middle of a fade.
    offer(5'd3);
    wait_rgb("pre_rst", 24'h404000);
    #2;
    rst_n = 1'b0;
    #1;
    check_rgb("arst_rgb", 24'h000000);
    check("arst_state", {30'd0, state}, {30'd0, ST_IDLE});
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_ready", {31'd0, bank_ready}, 32'd1);
    cyc(2);
    rst_n = 1'b1;
    offer(5'd3);
    wait_state("post_show", ST_SHOW, 4, n);
    cyc(6);
    check_rgb("post_pal3", 24'h000000);
`else
    // Instant colour change on accept.
    offer(5'd3);
    check_rgb("inst_rgb", 24'hFF8000);
    check("inst_state", {30'd0, state}, {30'd0, ST_SHOW});
    check("inst_busy", {31'd0, busy}, 32'd0);
    check("inst_ready", {31'd0, bank_ready}, 32'd1);

    // The hold is still timed by the prescaler: 3 ticks, which is 9..12 cycles.
    wait_state("decay", ST_DECAY, 20, n);
    check("hold_cycles", {31'd0, (n >= 9 && n <= 12)}, 32'd1);
    check_rgb("decay_rgb", 24'hFF8000);
    cyc(1);
    check_rgb("blank_rgb", 24'h000000);
    check("blank_state", {30'd0, state}, {30'd0, ST_IDLE});

    // Out-of-range index selects black.
    offer(5'd3);
    offer(5'd20);
    check_rgb("oor_rgb", 24'h000000);
    check("oor_state", {30'd0, state}, {30'd0, ST_SHOW});

    // Write collision, then the new value is visible.
    pal_we     = 1'b1;
    pal_addr   = 5'd5;
    pal_data   = 24'h0A141E;
    bank_valid = 1'b1;
    bank_idx   = 5'd5;
    cyc(1);
    pal_we     = 1'b0;
    bank_valid = 1'b0;
    check_rgb("coll_rgb", 24'h000000);
    offer(5'd5);
    check_rgb("pal5", 24'h0A141E);

    // A write to address 16 must not alias onto entry 0.
    pal_write(5'd16, 24'hFFFFFF);
    offer(5'd0);
    check_rgb("pal0", 24'h000000);

    // Asynchronous reset between edges, then the palette reads back black.
    offer(5'd3);
    check_rgb("pre_rst", 24'hFF8000);
    #2;
    rst_n = 1'b0;
    #1;
    check_rgb("arst_rgb", 24'h000000);
    check("arst_state", {30'd0, state}, {30'd0, ST_IDLE});
    cyc(2);
    rst_n = 1'b1;
    offer(5'd3);
    check_rgb("post_pal3", 24'h000000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
